// File: rtl/router_pkg.sv
// Shared types and constants for the router input port.
// - flit_type_t  : two-bit flit type held in the top bits of every flit
// - direction_t  : output port index; also the bit position in route_req
// - port_state_t : wormhole lock state of an input port
// - dest_x_lsb / dest_y_lsb : head-flit destination field positions,
//   packed directly below the type field (dest_x first, then dest_y)
package router_pkg;

  typedef enum logic [1:0] {
    FLIT_BODY      = 2'b00,
    FLIT_TAIL      = 2'b01,
    FLIT_HEAD      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    WEST  = 3'd2,
    EAST  = 3'd3,
    LOCAL = 3'd4
  } direction_t;

  typedef enum logic {
    ST_IDLE,
    ST_ROUTED
  } port_state_t;

  localparam int NUM_DIRS = 5;
  localparam int TYPE_W   = 2;

  function automatic int dest_x_lsb(input int flit_w, input int x_bits);
    return flit_w - TYPE_W - x_bits;
  endfunction

  function automatic int dest_y_lsb(input int flit_w, input int x_bits, input int y_bits);
    return flit_w - TYPE_W - x_bits - y_bits;
  endfunction

  function automatic logic [NUM_DIRS-1:0] dir_onehot(input direction_t d);
    return NUM_DIRS'(1) << d;
  endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Circular flit buffer for one router input port.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointers/count only)
//   push/push_data write request and flit; ignored while full
//   pop            read request; ignored while empty
//   front          oldest stored flit (don't-care when empty)
//   full, empty    occupancy flags
//   count          number of stored flits, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap naturally.
module router_input_fifo #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [FLIT_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [FLIT_WIDTH-1:0] front,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // A push while full is refused even if a pop frees a slot this cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign front   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/router_input_port.sv
// One 2D-mesh router input port: flit buffer, XY route computation on the
// head flit, wormhole route lock from head to tail, and pop control.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   position_x, position_y      this router's static mesh coordinates
//   data_in, data_in_valid      flit from the upstream link
//   stop_out                    FIFO full; upstream flit is not accepted
//   route_req                   one-hot request {L,E,W,S,N} to output arbiters
//   grant, out_stop             per-output grant and downstream stop
//   forwarding_head/_tail       head / tail (or head_tail) popped this cycle
//   data_out, data_out_valid    FIFO front to crossbar, valid on pop
//   protocol_err                sticky framing error
// Build option: ROUTER_INPUT_PROTOCOL_CHECK_EN enables the push-side framing
// checker; without it protocol_err is tied to 0.
module router_input_port
  import router_pkg::*;
#(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int X_BITS     = 3,
  parameter int Y_BITS     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_BITS-1:0]     position_x,
  input  logic [Y_BITS-1:0]     position_y,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  stop_out,
  output logic [NUM_DIRS-1:0]   route_req,
  input  logic [NUM_DIRS-1:0]   grant,
  input  logic [NUM_DIRS-1:0]   out_stop,
  output logic                  forwarding_head,
  output logic                  forwarding_tail,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  protocol_err
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int DX_LSB = dest_x_lsb(FLIT_WIDTH, X_BITS);
  localparam int DY_LSB = dest_y_lsb(FLIT_WIDTH, X_BITS, Y_BITS);

  logic [FLIT_WIDTH-1:0] front;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  pop;
  logic [TYPE_W-1:0]     front_type;
  logic [X_BITS-1:0]     dest_x;
  logic [Y_BITS-1:0]     dest_y;
  logic [NUM_DIRS-1:0]   comb_route;
  logic [NUM_DIRS-1:0]   route_q;
  port_state_t           state;
  port_state_t           state_nxt;
  logic                  load_route;

  router_input_fifo #(
    .FLIT_WIDTH (FLIT_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_in_valid & ~full),
    .push_data (data_in),
    .pop       (pop),
    .front     (front),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign stop_out   = (count == CW'(DEPTH));
  assign front_type = front[FLIT_WIDTH-1 -: TYPE_W];
  assign dest_x     = front[DX_LSB +: X_BITS];
  assign dest_y     = front[DY_LSB +: Y_BITS];

  // Dimension-ordered routing: resolve X fully before Y; y grows southward.
  always_comb begin
    comb_route = dir_onehot(LOCAL);
    if (dest_x > position_x)      comb_route = dir_onehot(EAST);
    else if (dest_x < position_x) comb_route = dir_onehot(WEST);
    else if (dest_y < position_y) comb_route = dir_onehot(NORTH);
    else if (dest_y > position_y) comb_route = dir_onehot(SOUTH);
  end

  // Only a head (type[1]) is ever decoded; a stray body/tail in IDLE stalls.
  // In ROUTED the latched route is held across empty gaps mid-packet.
  always_comb begin
    route_req = '0;
    if (!empty) begin
      if (state == ST_ROUTED)  route_req = route_q;
      else if (front_type[1])  route_req = comb_route;
    end
  end

  assign pop             = |(route_req & grant & ~out_stop);
  assign data_out        = front;
  assign data_out_valid  = pop;
  assign forwarding_head = pop & front_type[1];
  assign forwarding_tail = pop & front_type[0];

  always_comb begin
    state_nxt  = state;
    load_route = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pop && front_type == FLIT_HEAD) begin
          state_nxt  = ST_ROUTED;
          load_route = 1'b1;
        end
      end
      ST_ROUTED: begin
        if (pop && front_type == FLIT_TAIL) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      route_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_route) route_q <= comb_route;
    end
  end

`ifdef ROUTER_INPUT_PROTOCOL_CHECK_EN
  // Framing is tracked on the push side, independent of the pop-side lock,
  // so a bad flit is flagged as soon as it is accepted.
  logic              pkt_open;
  logic              err_q;
  logic              push_acc;
  logic [TYPE_W-1:0] in_type;

  assign push_acc = data_in_valid & ~full;
  assign in_type  = data_in[FLIT_WIDTH-1 -: TYPE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_open <= 1'b0;
      err_q    <= 1'b0;
    end else if (push_acc) begin
      if (in_type[1]) begin
        if (pkt_open) err_q <= 1'b1;
        pkt_open <= (in_type == FLIT_HEAD);
      end else begin
        if (!pkt_open) err_q <= 1'b1;
        if (in_type == FLIT_TAIL) pkt_open <= 1'b0;
      end
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_input_port.sv
module tb_router_input_port;

  localparam int FW    = 64;
  localparam int DEPTH = 4;
  localparam int XB    = 3;
  localparam int YB    = 3;
  localparam int G_TIE = 0;
  localparam int G_FIX = 1;
  localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_HT = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [XB-1:0] position_x;
  logic [YB-1:0] position_y;
  logic [FW-1:0] data_in;
  logic          data_in_valid;
  logic          stop_out;
  logic [4:0]    route_req;
  logic [4:0]    grant;
  logic [4:0]    out_stop;
  logic          forwarding_head;
  logic          forwarding_tail;
  logic [FW-1:0] data_out;
  logic          data_out_valid;
  logic          protocol_err;

  always #5 clk = ~clk;

  router_input_port #(.FLIT_WIDTH(FW), .DEPTH(DEPTH), .X_BITS(XB), .Y_BITS(YB)) dut (
    .clk(clk), .rst(rst), .position_x(position_x), .position_y(position_y),
    .data_in(data_in), .data_in_valid(data_in_valid), .stop_out(stop_out),
    .route_req(route_req), .grant(grant), .out_stop(out_stop),
    .forwarding_head(forwarding_head), .forwarding_tail(forwarding_tail),
    .data_out(data_out), .data_out_valid(data_out_valid), .protocol_err(protocol_err)
  );

  // Reference model: a queue of stored flits plus the packet currently
  // holding the port (if any) and the output it is locked to.
  logic [FW-1:0] q[$];
  bit            in_pkt;
  logic [4:0]    lock;
  bit            m_open;
  bit            m_err;
  int            gmode;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] xy(input logic [FW-1:0] f);
    logic [XB-1:0] dx;
    logic [YB-1:0] dy;
    dx = f[FW-3 -: XB];
    dy = f[FW-3-XB -: YB];
    if (dx > position_x) return 5'b01000;
    if (dx < position_x) return 5'b00100;
    if (dy < position_y) return 5'b00001;
    if (dy > position_y) return 5'b00010;
    return 5'b10000;
  endfunction

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [XB-1:0] dx,
                                       input logic [YB-1:0] dy);
    logic [FW-1:0] f;
    f = {$urandom, $urandom};
    f[FW-1 -: 2]       = t;
    f[FW-3 -: XB]      = dx;
    f[FW-3-XB -: YB]   = dy;
    return f;
  endfunction

  function automatic logic [4:0] model_req();
    if (q.size() == 0) return 5'b0;
    if (in_pkt)        return lock;
    if (q[0][FW-1])    return xy(q[0]);
    return 5'b0;
  endfunction

  // One clock cycle: inputs are already driven (just after a negedge).
  task automatic cyc();
    logic [4:0]    er;
    logic          ep;
    logic          es;
    logic          push_ok;
    logic [FW-1:0] fr;
    logic [1:0]    t;
    er = model_req();
    es = (q.size() == DEPTH);
    fr = (q.size() > 0) ? q[0] : '0;
    if (gmode == G_TIE) grant = er;
    ep = |(er & grant & ~out_stop);
    #1;
    check_eq("stop_out", 64'(stop_out), 64'(es));
    check_eq("route_req", 64'(route_req), 64'(er));
    check_eq("data_out_valid", 64'(data_out_valid), 64'(ep));
    check_eq("forwarding_head", 64'(forwarding_head), 64'(ep & fr[FW-1]));
    check_eq("forwarding_tail", 64'(forwarding_tail), 64'(ep & fr[FW-2]));
    check_eq("protocol_err", 64'(protocol_err), 64'(m_err));
    if (ep) check_eq("data_out", data_out, fr);
    @(posedge clk);
    if (rst) begin
      q.delete();
      in_pkt = 0; lock = '0; m_open = 0; m_err = 0;
    end else begin
      push_ok = data_in_valid && !es;
      if (ep) begin
        void'(q.pop_front());
        if (!in_pkt && fr[FW-1 -: 2] == T_HEAD) begin
          in_pkt = 1; lock = er;
        end else if (in_pkt && fr[FW-1 -: 2] == T_TAIL) begin
          in_pkt = 0;
        end
      end
      if (push_ok) begin
        q.push_back(data_in);
`ifdef ROUTER_INPUT_PROTOCOL_CHECK_EN
        t = data_in[FW-1 -: 2];
        if (t[1]) begin
          if (m_open) m_err = 1;
          m_open = (t == T_HEAD);
        end else begin
          if (!m_open) m_err = 1;
          if (t == T_TAIL) m_open = 0;
        end
`else
        t = 2'b00;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic push(input logic [FW-1:0] f);
    data_in = f; data_in_valid = 1'b1;
    cyc();
    data_in_valid = 1'b0;
  endtask

  // Directed look at an output just after the negedge, before cyc() samples.
  task automatic peek(input string tag, input logic [63:0] got, input logic [63:0] exp);
    #1;
    check_eq(tag, got, exp);
  endtask

  bit            g_open;
  int            g_left;
  logic [XB-1:0] g_dx;
  logic [YB-1:0] g_dy;
  logic [1:0]    g_t;

  initial begin
    rst = 1'b1; data_in = '0; data_in_valid = 1'b0;
    grant = '0; out_stop = '0; gmode = G_FIX;
    position_x = 3'd3; position_y = 3'd4;
    q.delete(); in_pkt = 0; lock = '0; m_open = 0; m_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    peek("rst_route_req", 64'(route_req), 64'(0));
    peek("rst_stop_out", 64'(stop_out), 64'(0));
    cyc();
    rst = 1'b0;

    // Single head_tail east, grant follows request: pops one cycle after push.
    gmode = G_TIE;
    push(mk(T_HT, 3'd4, 3'd4));
    peek("ht_east_req", 64'(route_req), 64'(5'b01000));
    cyc();

    // 4-flit packet north with grant withheld, then drained.
    gmode = G_FIX; grant = '0;
    push(mk(T_HEAD, 3'd3, 3'd3));
    push(mk(T_BODY, 3'd0, 3'd0));
    push(mk(T_BODY, 3'd0, 3'd0));
    push(mk(T_TAIL, 3'd0, 3'd0));
    for (int i = 0; i < 3; i++) begin
      peek("north_held", 64'(route_req), 64'(5'b00001));
      cyc();
    end
    gmode = G_TIE;
    repeat (4) cyc();
    push(mk(T_HT, 3'd2, 3'd4));
    peek("west_after_idle", 64'(route_req), 64'(5'b00100));
    cyc();

    // Fill to DEPTH, fifth flit refused, one pop frees a slot.
    gmode = G_FIX; grant = '0;
    push(mk(T_HEAD, 3'd5, 3'd1));
    repeat (3) push(mk(T_BODY, 3'd0, 3'd0));
    peek("full_stop", 64'(stop_out), 64'(1));
    push(mk(T_BODY, 3'd0, 3'd0));
    gmode = G_TIE; cyc();
    gmode = G_FIX; grant = '0;
    peek("slot_freed", 64'(stop_out), 64'(0));
    push(mk(T_TAIL, 3'd0, 3'd0));
    gmode = G_TIE; repeat (5) cyc();

    // Local destination, blocked by out_stop despite grant.
    push(mk(T_HT, 3'd3, 3'd4));
    gmode = G_FIX; grant = 5'b10000; out_stop = 5'b10000;
    peek("local_req", 64'(route_req), 64'(5'b10000));
    repeat (2) cyc();
    out_stop = '0;
    cyc();

    // Reset mid-packet after the head has left.
    gmode = G_TIE;
    push(mk(T_HEAD, 3'd0, 3'd0));
    push(mk(T_BODY, 3'd0, 3'd0));
    gmode = G_FIX; grant = '0;
    rst = 1'b1; cyc(); rst = 1'b0;
    peek("midrst_req", 64'(route_req), 64'(0));
    cyc();
    gmode = G_TIE;
    push(mk(T_HT, 3'd6, 3'd4));
    cyc();

    // Randomized well-formed traffic with random grants, stops and resets.
    g_open = 0; g_left = 0; g_dx = '0; g_dy = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!g_open) begin
        g_dx = 3'($urandom_range(0, 7));
        g_dy = 3'($urandom_range(0, 7));
        g_t  = ($urandom_range(0, 3) == 0) ? T_HT : T_HEAD;
      end else begin
        g_t  = (g_left > 0) ? T_BODY : T_TAIL;
      end
      data_in       = mk(g_t, g_dx, g_dy);
      data_in_valid = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 199) == 0);
      gmode         = ($urandom_range(0, 1) == 0) ? G_TIE : G_FIX;
      if (gmode == G_FIX) grant = 5'($urandom);
      out_stop      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      if (rst) begin
        g_open = 0;
      end else if (data_in_valid && q.size() < DEPTH) begin
        case (g_t)
          T_HEAD:  begin g_open = 1; g_left = $urandom_range(0, 3); end
          T_BODY:  g_left--;
          default: g_open = 0;
        endcase
      end
      cyc();
    end
    data_in_valid = 1'b0; rst = 1'b0; out_stop = '0; gmode = G_TIE;
    if (g_open) begin
      push(mk(T_TAIL, 3'd0, 3'd0));
    end
    repeat (8) cyc();
    peek("drained", 64'(route_req), 64'(0));

    // Body with no open packet: stalls, and is flagged when the checker is built.
    rst = 1'b1; cyc(); rst = 1'b0;
    push(mk(T_BODY, 3'd1, 3'd1));
`ifdef ROUTER_INPUT_PROTOCOL_CHECK_EN
    peek("orphan_err", 64'(protocol_err), 64'(1));
`else
    peek("orphan_err", 64'(protocol_err), 64'(0));
`endif
    peek("orphan_stall", 64'(route_req), 64'(0));
    repeat (3) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    peek("err_cleared", 64'(protocol_err), 64'(0));
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
